// File: rtl/radix2_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// radix2_butterfly_pipe
//
// Three-stage pipelined radix-2 DIT butterfly on signed Q(DATA_WIDTH-1)
// complex operands:
//   t  = sat(round(b * w))
//   y0 = sat(scl(a + t))
//   y1 = sat(scl(a - t))
// scl halves (round half up) when the per-transaction 'scale' bit is set.
//
// Stages: S1 registers the four full-precision partial products,
//         S2 registers the rounded/saturated twiddle product t,
//         S3 registers the outputs (out_valid/y*/sat).
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. The whole pipeline advances as one unit when
// adv = !out_valid || out_ready, and in_ready is exactly adv. While the
// output is stalled every stage and every output holds its value.
//
// Optional feature (macro BFLY_OVF_CNT_EN): adds ovf_clr / ovf_cnt, a
// saturating count of output handshakes that carried sat=1.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   a_re..w_im            operands a, b and twiddle w (signed)
//   scale                 1 = halve both outputs
//   out_valid / out_ready output handshake
//   y0_re..y1_im          butterfly results (signed)
//   sat                   result had at least one saturation event
//   ovf_clr, ovf_cnt      (BFLY_OVF_CNT_EN only) counter clear / value
// ---------------------------------------------------------------------------
module radix2_butterfly_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] a_re,
  input  logic signed [DATA_WIDTH-1:0] a_im,
  input  logic signed [DATA_WIDTH-1:0] b_re,
  input  logic signed [DATA_WIDTH-1:0] b_im,
  input  logic signed [DATA_WIDTH-1:0] w_re,
  input  logic signed [DATA_WIDTH-1:0] w_im,
  input  logic                         scale,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] y0_re,
  output logic signed [DATA_WIDTH-1:0] y0_im,
  output logic signed [DATA_WIDTH-1:0] y1_re,
  output logic signed [DATA_WIDTH-1:0] y1_im,
  output logic                         sat
`ifdef BFLY_OVF_CNT_EN
  ,
  input  logic                         ovf_clr,
  output logic [CNT_WIDTH-1:0]         ovf_cnt
`endif
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * W;      // one partial product
  localparam int SW = 2 * W + 2;  // working width, wide enough for every sum

  // Elaboration-time guard on the parameter ranges.
  if (DATA_WIDTH < 8 || DATA_WIDTH > 24 || CNT_WIDTH < 1) begin : g_param_check
    $error("radix2_butterfly_pipe: DATA_WIDTH must be 8..24 and CNT_WIDTH >= 1");
  end

  // Rounding constant 2^(W-2), and the clamp limits, all at working width.
  localparam logic signed [SW-1:0] RND  = {{(SW-W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};
  localparam logic signed [SW-1:0] MAXV = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [SW-1:0] ONE  = {{(SW-1){1'b0}}, 1'b1};

  // Clamp a working-width value to W bits; MSB of the result is the
  // saturation flag.
  function automatic logic [W:0] sat_fn(input logic signed [SW-1:0] x);
    logic [W:0] r;
    if (x > MAXV)      r = {1'b1, MAXV[W-1:0]};
    else if (x < MINV) r = {1'b1, MINV[W-1:0]};
    else               r = {1'b0, x[W-1:0]};
    return r;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // -------------------------------------------------------------------------
  // S1: full-precision partial products
  // -------------------------------------------------------------------------
  logic signed [PW-1:0] p_ac, p_bd, p_ad, p_bc;
  assign p_ac = b_re * w_re;
  assign p_bd = b_im * w_im;
  assign p_ad = b_re * w_im;
  assign p_bc = b_im * w_re;

  logic                 s1_valid, s1_scale;
  logic signed [W-1:0]  s1_a_re, s1_a_im;
  logic signed [PW-1:0] s1_ac, s1_bd, s1_ad, s1_bc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_ac    <= '0;
      s1_bd    <= '0;
      s1_ad    <= '0;
      s1_bc    <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_scale <= scale;
      s1_a_re  <= a_re;
      s1_a_im  <= a_im;
      s1_ac    <= p_ac;
      s1_bd    <= p_bd;
      s1_ad    <= p_ad;
      s1_bc    <= p_bc;
    end
  end

  // -------------------------------------------------------------------------
  // S2: t = sat(round(b*w)); round is add half-LSB then arithmetic shift
  // -------------------------------------------------------------------------
  logic signed [SW-1:0] t_re_sum, t_im_sum, t_re_rnd, t_im_rnd;
  logic [W:0]           t_re_c, t_im_c;

  always_comb begin
    t_re_sum = SW'(s1_ac) - SW'(s1_bd);
    t_im_sum = SW'(s1_ad) + SW'(s1_bc);
    t_re_rnd = (t_re_sum + RND) >>> (W - 1);
    t_im_rnd = (t_im_sum + RND) >>> (W - 1);
    t_re_c   = sat_fn(t_re_rnd);
    t_im_c   = sat_fn(t_im_rnd);
  end

  logic                s2_valid, s2_scale, s2_tsat;
  logic signed [W-1:0] s2_a_re, s2_a_im, s2_t_re, s2_t_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_tsat  <= 1'b0;
      s2_a_re  <= '0;
      s2_a_im  <= '0;
      s2_t_re  <= '0;
      s2_t_im  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_scale <= s1_scale;
      s2_tsat  <= t_re_c[W] | t_im_c[W];
      s2_a_re  <= s1_a_re;
      s2_a_im  <= s1_a_im;
      s2_t_re  <= t_re_c[W-1:0];
      s2_t_im  <= t_im_c[W-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // S3: y0 = sat(scl(a+t)), y1 = sat(scl(a-t))
  // -------------------------------------------------------------------------
  logic signed [SW-1:0] s0_re, s0_im, d0_re, d0_im;
  logic signed [SW-1:0] s0_re_sc, s0_im_sc, d0_re_sc, d0_im_sc;
  logic [W:0]           y0_re_c, y0_im_c, y1_re_c, y1_im_c;
  logic                 y_sat;

  always_comb begin
    s0_re = SW'(s2_a_re) + SW'(s2_t_re);
    s0_im = SW'(s2_a_im) + SW'(s2_t_im);
    d0_re = SW'(s2_a_re) - SW'(s2_t_re);
    d0_im = SW'(s2_a_im) - SW'(s2_t_im);
    if (s2_scale) begin
      s0_re_sc = (s0_re + ONE) >>> 1;
      s0_im_sc = (s0_im + ONE) >>> 1;
      d0_re_sc = (d0_re + ONE) >>> 1;
      d0_im_sc = (d0_im + ONE) >>> 1;
    end else begin
      s0_re_sc = s0_re;
      s0_im_sc = s0_im;
      d0_re_sc = d0_re;
      d0_im_sc = d0_im;
    end
    y0_re_c = sat_fn(s0_re_sc);
    y0_im_c = sat_fn(s0_im_sc);
    y1_re_c = sat_fn(d0_re_sc);
    y1_im_c = sat_fn(d0_im_sc);
    y_sat   = s2_tsat | y0_re_c[W] | y0_im_c[W] | y1_re_c[W] | y1_im_c[W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sat       <= 1'b0;
      y0_re     <= '0;
      y0_im     <= '0;
      y1_re     <= '0;
      y1_im     <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      sat       <= y_sat;
      y0_re     <= y0_re_c[W-1:0];
      y0_im     <= y0_im_c[W-1:0];
      y1_re     <= y1_re_c[W-1:0];
      y1_im     <= y1_im_c[W-1:0];
    end
  end

`ifdef BFLY_OVF_CNT_EN
  // -------------------------------------------------------------------------
  // Saturating count of delivered results that carried sat=1; clear wins.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && sat && (ovf_cnt != {CNT_WIDTH{1'b1}})) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_radix2_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// tb_radix2_butterfly_pipe
//
// Directed vectors with hand-computed results. The driver pushes the
// expected result (and its acceptance cycle) when a transfer is accepted;
// an independent monitor pops and compares on every output transfer, checks
// latency, and checks that a stalled output holds still with in_ready low.
// ---------------------------------------------------------------------------
module tb_radix2_butterfly_pipe;

  localparam int W  = 16;
  localparam int CW = 4;

  typedef logic [4*W:0] res_t;  // {sat, y0_re, y0_im, y1_re, y1_im}

  logic                clk, rst_n;
  logic                in_valid, in_ready, scale;
  logic signed [W-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic                out_valid, out_ready, sat;
  logic signed [W-1:0] y0_re, y0_im, y1_re, y1_im;
`ifdef BFLY_OVF_CNT_EN
  logic                ovf_clr;
  logic [CW-1:0]       ovf_cnt;
`endif

  res_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   check_lat;
  bit   held_valid = 0;
  res_t held;

  radix2_butterfly_pipe #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
`ifdef BFLY_OVF_CNT_EN
    .ovf_clr  (ovf_clr),
    .ovf_cnt  (ovf_cnt),
`endif
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_re     (a_re),
    .a_im     (a_im),
    .b_re     (b_re),
    .b_im     (b_im),
    .w_re     (w_re),
    .w_im     (w_im),
    .scale    (scale),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y0_re    (y0_re),
    .y0_im    (y0_im),
    .y1_re    (y1_re),
    .y1_im    (y1_im),
    .sat      (sat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic res_t mk(input bit s, input int y0r, input int y0i,
                              input int y1r, input int y1i);
    return {s, W'(y0r), W'(y0i), W'(y1r), W'(y1i)};
  endfunction

  task automatic chk(input string name, input logic [4*W:0] act, input logic [4*W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input int wr, input int wi, input bit sc, input res_t e);
    bit took;
    int guard;
    took  = 0;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a_re = W'(ar); a_im = W'(ai);
    b_re = W'(br); b_im = W'(bi);
    w_re = W'(wr); w_im = W'(wi);
    scale = sc;
    while (!took) begin
      #4;
      took = in_ready;
      if (took) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
      end
      @(posedge clk);
      if (!took) begin
        guard++;
        if (guard > 200) begin
          $display("FAIL send_timeout: in_ready stuck low");
          $fatal(1, "input never accepted");
        end
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 65'(exp_q.size()), 65'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    res_t got, e;
    int   a;
    if (rst_n) begin
      got = {sat, y0_re, y0_im, y1_re, y1_im};
      if (held_valid) begin
        chk("stall_hold", {out_valid, got}, {1'b1, held});
        held_valid = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", got, 65'h0 ^ ~got);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("result", got, e);
          if (check_lat) chk("latency", 65'(cyc - a), 65'd3);
        end
      end else if (out_valid && !out_ready) begin
        chk("stall_in_ready", 65'(in_ready), 65'd0);
        held       = got;
        held_valid = 1;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; scale = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
`ifdef BFLY_OVF_CNT_EN
    ovf_clr = 1'b0;
`endif
    check_lat = 1;
    #12;
    chk("rst_out_valid", 65'(out_valid), 65'd0);
    chk("rst_in_ready",  65'(in_ready),  65'd1);
    chk("rst_y",         {sat, y0_re, y0_im, y1_re, y1_im}, 65'd0);
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors: a, b, w, scale -> expected {sat, y0, y1}
    send( 1000, 0,  16384, 0,  32767, 0, 0, mk(0, 17384, 0, -15384, 0));
    send(32767, 0, -32768, 0, -32768, 0, 0, mk(1, 32767, 0, 0, 0));
    send(    3, 0,      0, 0,      0, 0, 1, mk(0, 2, 0, 2, 0));
    send(   -3, 0,      0, 0,      0, 0, 1, mk(0, -1, 0, -1, 0));
    send(  100, 200, 16384, 16384, 16384, -16384, 0, mk(0, 16484, 200, -16284, 200));
    send(    0, -30000, 0, 16384, 32767, 0, 0, mk(1, 0, -13616, 0, -32768));
    send(-32768, 32767, 0, 0, 0, 0, 1, mk(0, -16384, 16384, -16384, 16384));
    send(   10, 10, -3, 0, 16384, 0, 0, mk(0, 9, 10, 11, 10));
    send(32767, 0, -32768, 0, -32768, 0, 1, mk(1, 32767, 0, 0, 0));
    // isolated transaction after a bubble
    @(negedge clk);
    send( 1000, 0,  16384, 0,  32767, 0, 0, mk(0, 17384, 0, -15384, 0));
    drain();

    // Back-to-back burst with a downstream stall in the middle
    check_lat = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(i * 100, -i, 16384, 0, 32767, 0, 0,
               mk(0, i * 100 + 16384, -i, i * 100 - 16384, -i));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check_lat = 1;

    // Reset with three transactions in flight
    send(1, 0, 16384, 0, 32767, 0, 0, mk(0, 16385, 0, -16383, 0));
    send(2, 0, 16384, 0, 32767, 0, 0, mk(0, 16386, 0, -16382, 0));
    send(3, 0, 16384, 0, 32767, 0, 0, mk(0, 16387, 0, -16381, 0));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 65'(out_valid), 65'd0);
    chk("midrst_in_ready",  65'(in_ready),  65'd1);
    chk("midrst_y",         {sat, y0_re, y0_im, y1_re, y1_im}, 65'd0);
`ifdef BFLY_OVF_CNT_EN
    chk("midrst_ovf_cnt",   65'(ovf_cnt), 65'd0);
`endif
    exp_q.delete();
    acc_q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(negedge clk);
    send(-500, 0, 16384, 0, 32767, 0, 0, mk(0, 15884, 0, -16884, 0));
    drain();

`ifdef BFLY_OVF_CNT_EN
    for (int i = 0; i < 20; i++)
      send(32767, 0, -32768, 0, -32768, 0, 0, mk(1, 32767, 0, 0, 0));
    drain();
    chk("ovf_cnt_saturated", 65'(ovf_cnt), 65'd15);
    send(32767, 0, -32768, 0, -32768, 0, 0, mk(1, 32767, 0, 0, 0));
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    chk("ovf_clr_wins", 65'(ovf_cnt), 65'd0);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
